// File: rtl/q2_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : q2_mon_pkg
// Brief   : Shared types and saturating-count helpers for the Q2 event monitor.
// Revision: 1.0 - initial release
// ============================================================================
package q2_mon_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int unsigned C_MAX_CNT_W = 32;

    // All-ones value of a counter that is `width` bits wide.
    function automatic logic [C_MAX_CNT_W-1:0] sat_max(input int unsigned width);
        if (width >= C_MAX_CNT_W) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [C_MAX_CNT_W-1:0] sat_inc(
        input logic [C_MAX_CNT_W-1:0] cnt,
        input logic                   inc,
        input logic [C_MAX_CNT_W-1:0] max
    );
        if (inc && (cnt < max)) begin
            return cnt + 32'd1;
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/q2_event_monitor_edge.sv
`default_nettype none
// ============================================================================
// Module  : edge_rise_det
// Brief   : One-cycle rising-edge pulse; the history register updates every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module edge_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/q2_event_monitor.sv
`default_nettype none
// ============================================================================
// Module  : q2_event_monitor
// Brief   : Windowed rising-edge counter and b&c overlap detector for the Q2
//           circuit, reporting each window over a valid/ready interface.
// Revision: 1.0 - initial release
// ============================================================================
module q2_event_monitor
    import q2_mon_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             b,
    input  logic             c,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_b_cnt,
    output logic [CNT_W-1:0] rpt_c_cnt,
    output logic             rpt_both,
    output logic             overrun,
    output logic             busy
);

    localparam int                 c_win_w    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   c_sat_max  = CNT_W'(sat_max(CNT_W));

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_win_w-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_b_cnt;
    logic [CNT_W-1:0]   r_c_cnt;
    logic               r_both_seen;

    logic               w_rise_b;
    logic               w_rise_c;
    logic               w_win_end;
    logic               w_abandon;
    logic [CNT_W-1:0]   w_b_fin;
    logic [CNT_W-1:0]   w_c_fin;
    logic               w_both_fin;

    logic               r_rpt_valid;
    logic [CNT_W-1:0]   r_rpt_b_cnt;
    logic [CNT_W-1:0]   r_rpt_c_cnt;
    logic               r_rpt_both;
    logic               r_overrun;

    edge_rise_det u_rise_b (
        .clk    (clk),
        .rst    (rst),
        .i_d    (b),
        .o_rise (w_rise_b)
    );

    edge_rise_det u_rise_c (
        .clk    (clk),
        .rst    (rst),
        .i_d    (c),
        .o_rise (w_rise_c)
    );

    // Window totals including the current cycle's events.
    assign w_b_fin    = CNT_W'(sat_inc(C_MAX_CNT_W'(r_b_cnt), w_rise_b, C_MAX_CNT_W'(c_sat_max)));
    assign w_c_fin    = CNT_W'(sat_inc(C_MAX_CNT_W'(r_c_cnt), w_rise_c, C_MAX_CNT_W'(c_sat_max)));
    assign w_both_fin = r_both_seen | (b & c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_end   = 1'b0;
        w_abandon   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                // The final cycle always reports; en only decides whether to continue.
                if (r_win_cnt == c_win_last) begin
                    w_win_end   = 1'b1;
                    w_state_nxt = en ? COUNT : IDLE;
                end else if (!en) begin
                    w_abandon   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Accumulate only mid-window; IDLE, window end and abandon all clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt   <= '0;
            r_b_cnt     <= '0;
            r_c_cnt     <= '0;
            r_both_seen <= 1'b0;
        end else if ((r_state == COUNT) && !w_win_end && !w_abandon) begin
            r_win_cnt   <= r_win_cnt + c_win_w'(1);
            r_b_cnt     <= w_b_fin;
            r_c_cnt     <= w_c_fin;
            r_both_seen <= w_both_fin;
        end else begin
            r_win_cnt   <= '0;
            r_b_cnt     <= '0;
            r_c_cnt     <= '0;
            r_both_seen <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_valid <= 1'b0;
            r_rpt_b_cnt <= '0;
            r_rpt_c_cnt <= '0;
            r_rpt_both  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_win_end) begin
            r_rpt_valid <= 1'b1;
            r_rpt_b_cnt <= w_b_fin;
            r_rpt_c_cnt <= w_c_fin;
            r_rpt_both  <= w_both_fin;
            if (r_rpt_valid && !rpt_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_rpt_valid && rpt_ready) begin
            r_rpt_valid <= 1'b0;
        end
    end

    assign rpt_valid = r_rpt_valid;
    assign rpt_b_cnt = r_rpt_b_cnt;
    assign rpt_c_cnt = r_rpt_c_cnt;
    assign rpt_both  = r_rpt_both;
    assign overrun   = r_overrun;
    assign busy      = (r_state == COUNT);

endmodule
`default_nettype wire

// File: tb/tb_q2_event_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_q2_event_monitor
// Brief   : Self-checking bench for q2_event_monitor at CNT_W=8 and CNT_W=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_q2_event_monitor;

    localparam int WINDOW = 16;

    logic       clk = 1'b0;
    logic       rst, en, b, c, rpt_ready;
    logic       v8, both8, ovr8, busy8;
    logic [7:0] bc8, cc8;
    logic       v2, both2, ovr2, busy2;
    logic [1:0] bc2, cc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    q2_event_monitor #(.WINDOW(WINDOW), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .b(b), .c(c),
        .rpt_valid(v8), .rpt_ready(rpt_ready), .rpt_b_cnt(bc8), .rpt_c_cnt(cc8),
        .rpt_both(both8), .overrun(ovr8), .busy(busy8)
    );

    q2_event_monitor #(.WINDOW(WINDOW), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .b(b), .c(c),
        .rpt_valid(v2), .rpt_ready(rpt_ready), .rpt_b_cnt(bc2), .rpt_c_cnt(cc2),
        .rpt_both(both2), .overrun(ovr2), .busy(busy2)
    );

    // Reference model: true (unbounded) edge counts, clipped only when compared.
    logic m_bq, m_cq, m_run, m_both, m_v, m_rboth, m_ovr;
    int   m_pos, m_nb, m_nc, m_rb, m_rc;
    logic m_rise_b, m_rise_c, m_end;
    assign m_rise_b = b & ~m_bq;
    assign m_rise_c = c & ~m_cq;
    assign m_end    = m_run && (m_pos == WINDOW - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_bq <= 1'b0; m_cq <= 1'b0; m_run <= 1'b0; m_both <= 1'b0;
            m_v <= 1'b0; m_rboth <= 1'b0; m_ovr <= 1'b0;
            m_pos <= 0; m_nb <= 0; m_nc <= 0; m_rb <= 0; m_rc <= 0;
        end else begin
            m_bq <= b;
            m_cq <= c;
            if (m_end) begin
                m_rb    <= m_nb + int'(m_rise_b);
                m_rc    <= m_nc + int'(m_rise_c);
                m_rboth <= m_both | (b & c);
                m_v     <= 1'b1;
                if (m_v && !rpt_ready) m_ovr <= 1'b1;
                m_nb <= 0; m_nc <= 0; m_both <= 1'b0; m_pos <= 0;
                m_run <= en;
            end else begin
                if (m_v && rpt_ready) m_v <= 1'b0;
                if (m_run && en) begin
                    m_pos  <= m_pos + 1;
                    m_nb   <= m_nb + int'(m_rise_b);
                    m_nc   <= m_nc + int'(m_rise_c);
                    m_both <= m_both | (b & c);
                end else if (m_run) begin
                    m_run <= 1'b0; m_pos <= 0; m_nb <= 0; m_nc <= 0; m_both <= 1'b0;
                end else if (en) begin
                    m_run <= 1'b1; m_pos <= 0;
                end
            end
        end
    end

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; b = 1'b0; c = 1'b0; rpt_ready = 1'b0;
        cyc; cyc;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; b = 1'b1; c = 1'b1; en = 1'b1; rpt_ready = 1'b0;
        cyc; cyc;
        checks++;
        if ({v8, bc8, cc8, both8, ovr8, busy8} !== 21'h0) begin
            errors++;
            $display("FAIL reset_out8: got %h expected 0", {v8, bc8, cc8, both8, ovr8, busy8});
        end
        checks++;
        if ({v2, bc2, cc2, both2, ovr2, busy2} !== 9'h0) begin
            errors++;
            $display("FAIL reset_out2: got %h expected 0", {v2, bc2, cc2, both2, ovr2, busy2});
        end
        rst = 1'b0; en = 1'b0; b = 1'b0; c = 1'b0;
        repeat (3) cyc;
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy8);
        end
        en = 1'b1;
        cyc;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_en: busy got %b expected 1", busy8);
        end
        do_reset;
    endtask

    task automatic test_basic;
        do_reset;
        en = 1'b1;
        cyc;
        for (int k = 0; k < WINDOW; k++) begin
            b = (k == 2) || (k == 5) || (k == 9);
            c = (k == 12);
            if (k == WINDOW - 1) en = 1'b0;
            checks++;
            if (busy8 !== 1'b1 || v8 !== 1'b0) begin
                errors++;
                $display("FAIL basic_in_window k=%0d: busy/valid got %b%b expected 10", k, busy8, v8);
            end
            cyc;
        end
        b = 1'b0; c = 1'b0;
        checks++;
        if ({v8, bc8, cc8, both8, busy8} !== {1'b1, 8'd3, 8'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_report: got v=%b b=%0d c=%0d both=%b busy=%b expected v=1 b=3 c=1 both=0 busy=0",
                     v8, bc8, cc8, both8, busy8);
        end
        checks++;
        if (bc2 !== 2'd3 || cc2 !== 2'd1) begin
            errors++;
            $display("FAIL basic_report_w2: got b=%0d c=%0d expected b=3 c=1", bc2, cc2);
        end
        rpt_ready = 1'b1;
        cyc;
        rpt_ready = 1'b0;
        checks++;
        if (v8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: valid got %b expected 0", v8);
        end
    endtask

    task automatic test_hold_and_both;
        do_reset;
        rpt_ready = 1'b1; en = 1'b1;
        cyc;
        for (int k = 0; k < 2 * WINDOW; k++) begin
            b = 1'b1;
            c = (k == 3);
            if (k == 2 * WINDOW - 1) en = 1'b0;
            if (k == WINDOW) begin
                checks++;
                if ({v8, bc8, cc8, both8} !== {1'b1, 8'd1, 8'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL hold_first: got v=%b b=%0d c=%0d both=%b expected v=1 b=1 c=1 both=1",
                             v8, bc8, cc8, both8);
                end
            end
            cyc;
        end
        b = 1'b0; c = 1'b0;
        checks++;
        if ({v8, bc8, cc8, both8} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL hold_second: got v=%b b=%0d c=%0d both=%b expected v=1 b=0 c=0 both=0",
                     v8, bc8, cc8, both8);
        end
    endtask

    task automatic test_saturate;
        do_reset;
        en = 1'b1;
        cyc;
        for (int k = 0; k < WINDOW; k++) begin
            b = (k % 2 == 0);
            c = 1'b0;
            if (k == WINDOW - 1) en = 1'b0;
            cyc;
        end
        b = 1'b0;
        checks++;
        if (v2 !== 1'b1 || bc2 !== 2'd3) begin
            errors++;
            $display("FAIL saturate_w2: got v=%b b=%0d expected v=1 b=3", v2, bc2);
        end
        checks++;
        if (bc8 !== 8'd8) begin
            errors++;
            $display("FAIL saturate_w8: got b=%0d expected 8", bc8);
        end
    endtask

    task automatic test_overrun;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset;
            en = 1'b1;
            cyc;
            for (int k = 0; k < 2 * WINDOW; k++) begin
                b = (k == 4) || (k == 20) || (k == 24);
                c = 1'b0;
                if (k == 2 * WINDOW - 1) begin
                    en = 1'b0;
                    rpt_ready = (pass == 1);
                end
                if (k == WINDOW) begin
                    checks++;
                    if ({v8, bc8, ovr8} !== {1'b1, 8'd1, 1'b0}) begin
                        errors++;
                        $display("FAIL overrun_first pass=%0d: got v=%b b=%0d ovr=%b expected v=1 b=1 ovr=0",
                                 pass, v8, bc8, ovr8);
                    end
                end
                cyc;
            end
            rpt_ready = 1'b0; b = 1'b0;
            checks++;
            if ({v8, bc8, ovr8, ovr2} !== {1'b1, 8'd2, (pass == 0), (pass == 0)}) begin
                errors++;
                $display("FAIL overrun_second pass=%0d: got v=%b b=%0d ovr=%b/%b expected v=1 b=2 ovr=%0d",
                         pass, v8, bc8, ovr8, ovr2, (pass == 0));
            end
            repeat (3) cyc;
            checks++;
            if (ovr8 !== (pass == 0) || v8 !== 1'b1) begin
                errors++;
                $display("FAIL overrun_sticky pass=%0d: got ovr=%b v=%b expected ovr=%0d v=1",
                         pass, ovr8, v8, (pass == 0));
            end
        end
        do_reset;
        checks++;
        if (ovr8 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_cleared_by_rst: got %b expected 0", ovr8);
        end
    endtask

    task automatic test_abort;
        logic seen;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset;
            en = 1'b1;
            cyc;
            for (int k = 0; k < 5; k++) begin
                b = (k == 1);
                cyc;
            end
            b = 1'b1;
            if (pass == 0) en = 1'b0;
            else rst = 1'b1;
            cyc;
            rst = 1'b0; en = 1'b0; b = 1'b0;
            checks++;
            if ({v8, bc8, cc8, both8, ovr8, busy8} !== 21'h0) begin
                errors++;
                $display("FAIL abort_out pass=%0d: got %h expected 0", pass, {v8, bc8, cc8, both8, ovr8, busy8});
            end
            seen = 1'b0;
            repeat (2 * WINDOW) begin
                cyc;
                seen = seen | v8 | v2;
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_report pass=%0d: valid seen %b expected 0", pass, seen);
            end
        end
        en = 1'b1;
        cyc;
        for (int k = 0; k < WINDOW; k++) begin
            if (k == WINDOW - 1) en = 1'b0;
            cyc;
        end
        checks++;
        if ({v8, bc8} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL abort_fresh_window: got v=%b b=%0d expected v=1 b=0", v8, bc8);
        end
    endtask

    task automatic test_random;
        do_reset;
        for (int n = 0; n < 3000; n++) begin
            checks++;
            if ({v8, bc8, cc8, both8, ovr8, busy8} !==
                {m_v, 8'(clip(m_rb, 255)), 8'(clip(m_rc, 255)), m_rboth, m_ovr, m_run}) begin
                errors++;
                $display("FAIL random_w8 n=%0d: got v=%b b=%0d c=%0d both=%b ovr=%b busy=%b expected v=%b b=%0d c=%0d both=%b ovr=%b busy=%b",
                         n, v8, bc8, cc8, both8, ovr8, busy8,
                         m_v, clip(m_rb, 255), clip(m_rc, 255), m_rboth, m_ovr, m_run);
            end
            checks++;
            if ({v2, bc2, cc2, both2, ovr2, busy2} !==
                {m_v, 2'(clip(m_rb, 3)), 2'(clip(m_rc, 3)), m_rboth, m_ovr, m_run}) begin
                errors++;
                $display("FAIL random_w2 n=%0d: got v=%b b=%0d c=%0d both=%b ovr=%b busy=%b expected v=%b b=%0d c=%0d both=%b ovr=%b busy=%b",
                         n, v2, bc2, cc2, both2, ovr2, busy2,
                         m_v, clip(m_rb, 3), clip(m_rc, 3), m_rboth, m_ovr, m_run);
            end
            rst       = ($urandom_range(0, 399) == 0);
            en        = ($urandom_range(0, 29) != 0);
            b         = 1'($urandom_range(0, 1));
            c         = ($urandom_range(0, 2) == 0);
            rpt_ready = ($urandom_range(0, 3) == 0);
            cyc;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; b = 1'b0; c = 1'b0; rpt_ready = 1'b0;
        test_reset;
        test_basic;
        test_hold_and_both;
        test_saturate;
        test_overrun;
        test_abort;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
